// File: rtl/uart_line_buffer.sv
// Line buffer for a UART TX path. Bytes are collected until a newline arrives,
// the buffer fills, or the line goes idle too long. The line then drains byte by byte.
module uart_line_buffer #(
  parameter int LineLen     = 64,
  parameter int IdleTimeout = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  input  logic [7:0]  char_data_i,
  output logic        line_valid_o,
  input  logic        line_ready_i,
  output logic [7:0]  line_data_o,
  output logic        line_last_o,
  output logic        line_trunc_o,
  output logic [31:0] lines_o
);

  localparam int AddrW = (LineLen > 1) ? $clog2(LineLen) : 1;
  localparam int CntW  = AddrW + 1;
  localparam int IdleW = $clog2(IdleTimeout + 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state_reg;
  logic [CntW-1:0]   cnt_reg;
  logic [CntW-1:0]   rd_reg;
  logic [IdleW-1:0]  idle_reg;
  logic              trunc_reg;
  logic [31:0]       lines_reg;
  logic [7:0]        data_reg;
  logic [7:0]        buf_mem [LineLen];

  logic            accept;
  logic            is_nl;
  logic            full_hit;
  logic            timeout_hit;
  logic            drain_hs;
  logic            is_last;
  logic [CntW-1:0] cnt_inc;
  logic [CntW-1:0] rd_inc;

  assign accept      = (state_reg == FILL) && char_valid_i;
  assign is_nl       = (char_data_i == 8'h0A);
  assign cnt_inc     = cnt_reg + 1'b1;
  assign full_hit    = (cnt_inc == CntW'(LineLen));
  // The idle counter only leaves zero with a partial line, so no separate cnt check.
  assign timeout_hit = (state_reg == FILL) && !char_valid_i && (idle_reg == IdleW'(IdleTimeout));
  assign drain_hs    = (state_reg == DRAIN) && line_ready_i;
  assign is_last     = (rd_reg == cnt_reg - 1'b1);
  assign rd_inc      = rd_reg + 1'b1;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_mem[cnt_reg[AddrW-1:0]] <= char_data_i;
    end
  end

  // Registered read port. The first byte of a line is captured straight from the
  // input so it is ready on the first DRAIN cycle; later bytes are prefetched
  // from storage on each handshake.
  always_ff @(posedge clk_i) begin
    if (accept && (cnt_reg == '0)) begin
      data_reg <= char_data_i;
    end else if (drain_hs && !is_last) begin
      data_reg <= buf_mem[rd_inc[AddrW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      idle_reg  <= '0;
      trunc_reg <= 1'b0;
      lines_reg <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            cnt_reg  <= cnt_inc;
            idle_reg <= '0;
            if (is_nl || full_hit) begin
              state_reg <= DRAIN;
              trunc_reg <= !is_nl;
            end
          end else if (timeout_hit) begin
            state_reg <= DRAIN;
            trunc_reg <= 1'b1;
            idle_reg  <= '0;
          end else if (cnt_reg != '0) begin
            idle_reg <= idle_reg + 1'b1;
          end else begin
            idle_reg <= '0;
          end
        end
        DRAIN: begin
          if (line_ready_i) begin
            if (is_last) begin
              state_reg <= FILL;
              cnt_reg   <= '0;
              rd_reg    <= '0;
              idle_reg  <= '0;
              trunc_reg <= 1'b0;
              lines_reg <= lines_reg + 32'd1;
            end else begin
              rd_reg <= rd_inc;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign char_ready_o = (state_reg == FILL);
  assign line_valid_o = (state_reg == DRAIN);
  assign line_data_o  = data_reg;
  assign line_last_o  = (state_reg == DRAIN) && is_last;
  assign line_trunc_o = trunc_reg;
  assign lines_o      = lines_reg;

endmodule
